// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: unified memory port between the sequencer and memory
interface ctrl_sequencer_if #(parameter int IR_W = 16);
  logic            mem_req;
  logic            mem_we;
  logic            addr_sel;
  logic            mem_ready;
  logic [IR_W-1:0] mem_rdata;
  modport master (output mem_req, mem_we, addr_sel, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_we, addr_sel, output mem_ready, mem_rdata);
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: one-hot multi-cycle control FSM with memory handshake, timeout and branch evaluation
module ctrl_sequencer #(
  parameter int IR_W        = 16,
  parameter int REG_AW      = 3,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  ctrl_sequencer_if.master  mem,
  input  logic [3:0]        psr_flags,
  output logic [IR_W-1:0]   ir,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [REG_AW-1:0] rf_ra,
  output logic [REG_AW-1:0] rf_rb,
  output logic [REG_AW-1:0] rf_wa,
  output logic              rf_we,
  output logic              wb_sel,
  output logic [3:0]        alu_op,
  output logic              alu_imm,
  output logic [IR_W-1:0]   imm_ext,
  output logic              psr_we,
  output logic [6:0]        state,
  output logic              fault,
  output logic [1:0]        fault_code
);
  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    FETCH  = 7'b0000010,
    DECODE = 7'b0000100,
    EXEC   = 7'b0001000,
    MEM    = 7'b0010000,
    WB     = 7'b0100000,
    FAULT  = 7'b1000000
  } st_t;
  st_t              st, st_n;
  logic [1:0]       fc_n;
  logic [TMO_W-1:0] cnt;
  logic             cond_ok, tmo;
  logic [1:0]        op;
  logic [3:0]        fn;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [IR_W-1:0]   zext, sext;
  assign op    = ir[IR_W-1:IR_W-2];
  assign fn    = ir[IR_W-3:IR_W-6];
  assign rd    = ir[3*REG_AW-1:2*REG_AW];
  assign rs1   = ir[2*REG_AW-1:REG_AW];
  assign rs2   = ir[REG_AW-1:0];
  assign zext  = {{(IR_W-REG_AW){1'b0}}, rs2};
  assign sext  = {{(IR_W-3*REG_AW){ir[3*REG_AW-1]}}, ir[3*REG_AW-1:0]};
  assign state = st;
  assign tmo   = (MEM_TIMEOUT != 0) && (cnt == TMO_W'(MEM_TIMEOUT));
  // psr_flags = {N,Z,V,C}
  always_comb begin
    cond_ok = 1'b0;
    case (fn)
      4'd0: cond_ok = 1'b1;
      4'd1: cond_ok = psr_flags[2];
      4'd2: cond_ok = ~psr_flags[2];
      4'd3: cond_ok = ~psr_flags[2] & ~(psr_flags[3] ^ psr_flags[1]);
      4'd4: cond_ok = psr_flags[2] | (psr_flags[3] ^ psr_flags[1]);
      4'd5: cond_ok = ~(psr_flags[3] ^ psr_flags[1]);
      4'd6: cond_ok = psr_flags[3] ^ psr_flags[1];
      4'd7: cond_ok = psr_flags[0];
      4'd8: cond_ok = ~psr_flags[0];
      default: cond_ok = 1'b0;
    endcase
  end
  always_comb begin
    st_n         = st;
    fc_n         = fault_code;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    rf_ra        = '0;
    rf_rb        = '0;
    rf_wa        = '0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    alu_op       = 4'd0;
    alu_imm      = 1'b0;
    imm_ext      = '0;
    psr_we       = 1'b0;
    case (st)
      IDLE: st_n = run ? FETCH : IDLE;
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) st_n = DECODE;
        else if (tmo) begin
          st_n = FAULT;
          fc_n = 2'b01;
        end
      end
      DECODE: begin
        pc_inc = 1'b1;
        rf_ra  = rs1;
        rf_rb  = rs2;
        st_n   = EXEC;
      end
      EXEC: begin
        if (op == 2'b11) begin
          imm_ext = sext;
          if (fn > 4'd8) begin
            st_n = FAULT;
            fc_n = 2'b10;
          end else begin
            pc_load = cond_ok;
            st_n    = run ? FETCH : IDLE;
          end
        end else begin
          imm_ext = zext;
          alu_op  = op[1] ? 4'd0 : fn;
          alu_imm = op[1] | op[0];
          psr_we  = ~op[1];
          st_n    = op[1] ? MEM : WB;
        end
      end
      MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = fn[0];
        if (mem.mem_ready) st_n = fn[0] ? (run ? FETCH : IDLE) : WB;
        else if (tmo) begin
          st_n = FAULT;
          fc_n = 2'b01;
        end
      end
      WB: begin
        rf_we  = 1'b1;
        rf_wa  = rd;
        wb_sel = (op == 2'b10);
        st_n   = run ? FETCH : IDLE;
      end
      FAULT: st_n = FAULT;
      default: st_n = IDLE;
    endcase
  end
  // counter restarts on every state change, so it only ever counts waits of the current access
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      ir         <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      cnt        <= '0;
    end else begin
      st         <= st_n;
      fault_code <= fc_n;
      fault      <= fault | (st_n == FAULT);
      cnt        <= (st_n != st) ? '0 : (mem.mem_req && !mem.mem_ready && !(&cnt)) ? cnt + 1'b1 : cnt;
      if (st == FETCH && mem.mem_ready) ir <= mem.mem_rdata;
    end
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed checks of fetch/execute flow, handshake waits, branches, faults and reset
module tb_ctrl_sequencer;
  logic        clk = 1'b0;
  logic        rst, run;
  logic [3:0]  psr_flags;
  logic [15:0] ir, imm_ext;
  logic        pc_inc, pc_load, rf_we, wb_sel, alu_imm, psr_we, fault;
  logic [2:0]  rf_ra, rf_rb, rf_wa;
  logic [3:0]  alu_op;
  logic [6:0]  state;
  logic [1:0]  fault_code;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  ctrl_sequencer_if #(.IR_W(16)) bus ();
  ctrl_sequencer #(.IR_W(16), .REG_AW(3), .TMO_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .mem(bus), .psr_flags(psr_flags),
    .ir(ir), .pc_inc(pc_inc), .pc_load(pc_load), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_wa(rf_wa), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op), .alu_imm(alu_imm),
    .imm_ext(imm_ext), .psr_we(psr_we), .state(state), .fault(fault), .fault_code(fault_code)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; run = 1'b0; psr_flags = 4'b0000;
    bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0000;
    step(2);
    chk("rst_state", state, 7'b0000001);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_fault", {fault, fault_code}, 3'b000);
    // T1: ALU fn=0101 rd=2 rs1=1 rs2=3
    rst = 1'b0; run = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 16'h148B;
    step();
    chk("t1_fetch", {state, bus.mem_req, bus.addr_sel, bus.mem_we}, {7'b0000010, 3'b100});
    step();
    chk("t1_decode", {state, pc_inc, rf_ra, rf_rb}, {7'b0000100, 1'b1, 3'd1, 3'd3});
    chk("t1_ir", ir, 16'h148B);
    bus.mem_ready = 1'b0;
    step();
    chk("t1_exec", {state, psr_we, alu_op, alu_imm}, {7'b0001000, 1'b1, 4'b0101, 1'b0});
    step();
    chk("t1_wb", {state, rf_we, rf_wa, wb_sel, psr_we}, {7'b0100000, 1'b1, 3'd2, 1'b0, 1'b0});
    // T2: load rd=4 rs1=5 rs2=2, three wait cycles in MEM
    bus.mem_rdata = 16'h812A; bus.mem_ready = 1'b1;
    step(2);
    bus.mem_ready = 1'b0;
    step();
    chk("t2_exec", {state, alu_op, alu_imm, imm_ext}, {7'b0001000, 4'd0, 1'b1, 16'h0002});
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_mem_wait", {state, bus.mem_req, bus.addr_sel, bus.mem_we}, {7'b0010000, 3'b110});
      if (i == 3) bus.mem_ready = 1'b1;
      step();
    end
    chk("t2_wb", {state, rf_we, rf_wa, wb_sel}, {7'b0100000, 1'b1, 3'd4, 1'b1});
    // T3: branch cond=1 (Z) with imm -2
    bus.mem_rdata = 16'hC5FE; psr_flags = 4'b0100;
    step(3);
    chk("t3_z1", {state, pc_load, imm_ext}, {7'b0001000, 1'b1, 16'hFFFE});
    psr_flags = 4'b0000;
    step(3);
    chk("t3_z0", {state, pc_load}, {7'b0001000, 1'b0});
    bus.mem_rdata = 16'hCC00; psr_flags = 4'b1010;
    step(3);
    chk("t3_gt", pc_load, 1'b1);
    bus.mem_rdata = 16'hF000;
    step(3);
    chk("t3_illegal_exec", pc_load, 1'b0);
    step();
    chk("t3_fault", {state, fault, fault_code, bus.mem_req}, {7'b1000000, 1'b1, 2'b10, 1'b0});
    // T4: fetch timeout
    rst = 1'b1; bus.mem_ready = 1'b0;
    step();
    chk("t4_rst", {state, fault, fault_code}, {7'b0000001, 3'b000});
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("t4_fetch_wait", {state, bus.mem_req}, {7'b0000010, 1'b1});
      step();
    end
    chk("t4_fault", {state, fault, fault_code, bus.mem_req}, {7'b1000000, 1'b1, 2'b01, 1'b0});
    step(3);
    chk("t4_sticky", {state, fault, fault_code}, {7'b1000000, 1'b1, 2'b01});
    rst = 1'b1;
    step();
    chk("t4_clear", {state, fault}, {7'b0000001, 1'b0});
    // T5: run dropped during store EXEC
    rst = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 16'h8409;
    step(3);
    chk("t5_exec", state, 7'b0001000);
    run = 1'b0;
    step();
    chk("t5_mem", {state, bus.mem_req, bus.addr_sel, bus.mem_we}, {7'b0010000, 3'b111});
    step();
    chk("t5_idle", {state, bus.mem_req, rf_we}, {7'b0000001, 2'b00});
    step();
    chk("t5_park", {state, bus.mem_req}, {7'b0000001, 1'b0});
    run = 1'b1;
    step();
    chk("t5_resume", {state, bus.mem_req}, {7'b0000010, 1'b1});
    // T6: reset while waiting in MEM
    bus.mem_rdata = 16'h812A;
    step();
    bus.mem_ready = 1'b0;
    step(3);
    chk("t6_wait", state, 7'b0010000);
    rst = 1'b1;
    step();
    chk("t6_rst", {state, bus.mem_req, bus.addr_sel, rf_we, psr_we, pc_inc, pc_load},
        {7'b0000001, 6'b000000});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
